// File: rtl/uart_receiver.sv
// uart_receiver: receive half of the DTI UART.
// 16x oversampled frame recovery (5-8 data bits, optional even/odd parity,
// 1 or 2 stop bits) with registered data and status flags for the host.
// Optional feature macro: DTI_UART_RX_OVERRUN_EN enables the stt_overrun flag;
// without it stt_overrun is tied low and has no register.
`timescale 1ns/1ps

`ifndef CFG_DATA_WIDTH
`define CFG_DATA_WIDTH 8
`endif

module uart_receiver #(
    parameter int unsigned DATA_WIDTH = `CFG_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clken,
    input  logic                  rx,
    input  logic [1:0]            cfg_data_bit_num,
    input  logic                  cfg_stop_bit_num,
    input  logic                  cfg_parity_en,
    input  logic                  cfg_parity_type,
    input  logic                  host_read_stt_rx_done,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  stt_rx_done,
    output logic                  stt_parity_err,
    output logic                  stt_frame_err,
    output logic                  stt_overrun,
    output logic                  rts_n
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;

    state_e                state_q, state_d;
    logic [1:0]            rx_sync_q, rx_sync_d;
    logic                  rx_s;
    logic [3:0]            tick_cnt_q, tick_cnt_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic [7:0]            shift_q, shift_d;
    logic                  par_err_q, par_err_d;
    logic                  frm_err_q, frm_err_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_done_q, rx_done_d;
    logic                  parity_flag_q, parity_flag_d;
    logic                  frame_flag_q, frame_flag_d;
    logic                  frame_done;
    logic [7:0]            data_mask;
    logic [2:0]            last_bit;

    // Index of the final data bit is N-1 = 4 + cfg_data_bit_num.
    assign last_bit  = {1'b1, cfg_data_bit_num};
    assign data_mask = 8'hFF >> (2'd3 - cfg_data_bit_num);
    assign rx_s      = rx_sync_q[1];

    // Two-flop synchronizer for the asynchronous serial input.
    always_comb begin
        rx_sync_d = {rx_sync_q[0], rx};
    end

    // Frame state machine: next state, counters, shift register, pending errors.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        par_err_d  = par_err_q;
        frm_err_d  = frm_err_q;
        frame_done = 1'b0;
        if (clken) begin
            case (state_q)
                ST_IDLE: begin
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    par_err_d  = 1'b0;
                    frm_err_d  = 1'b0;
                    if (!rx_s) state_d = ST_START;
                end
                ST_START: begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == 4'd7) begin
                        tick_cnt_d = '0;
                        state_d    = rx_s ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == 4'd15) begin
                        shift_d[bit_cnt_q] = rx_s;
                        if (bit_cnt_q == last_bit) begin
                            bit_cnt_d = '0;
                            state_d   = cfg_parity_en ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == 4'd15) begin
                        par_err_d = rx_s != ((^(shift_q & data_mask)) ^ cfg_parity_type);
                        state_d   = ST_STOP;
                    end
                end
                ST_STOP: begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == 4'd15) begin
                        if (!rx_s) frm_err_d = 1'b1;
                        if (stop_cnt_q == cfg_stop_bit_num) begin
                            frame_done = 1'b1;
                            state_d    = ST_IDLE;
                        end else begin
                            stop_cnt_d = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Status update: a completing frame takes priority over a host read.
    always_comb begin
        rx_data_d     = rx_data_q;
        rx_done_d     = rx_done_q;
        parity_flag_d = parity_flag_q;
        frame_flag_d  = frame_flag_q;
        if (frame_done) begin
            rx_data_d      = '0;
            rx_data_d[7:0] = shift_q & data_mask;
            rx_done_d      = 1'b1;
            parity_flag_d  = par_err_q;
            frame_flag_d   = frm_err_d;
        end else if (host_read_stt_rx_done) begin
            rx_done_d     = 1'b0;
            parity_flag_d = 1'b0;
            frame_flag_d  = 1'b0;
        end
    end

    // State, counters and status registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            rx_sync_q     <= 2'b11;
            tick_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            stop_cnt_q    <= 1'b0;
            shift_q       <= '0;
            par_err_q     <= 1'b0;
            frm_err_q     <= 1'b0;
            rx_data_q     <= '0;
            rx_done_q     <= 1'b0;
            parity_flag_q <= 1'b0;
            frame_flag_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            rx_sync_q     <= rx_sync_d;
            tick_cnt_q    <= tick_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            stop_cnt_q    <= stop_cnt_d;
            shift_q       <= shift_d;
            par_err_q     <= par_err_d;
            frm_err_q     <= frm_err_d;
            rx_data_q     <= rx_data_d;
            rx_done_q     <= rx_done_d;
            parity_flag_q <= parity_flag_d;
            frame_flag_q  <= frame_flag_d;
        end
    end

`ifdef DTI_UART_RX_OVERRUN_EN
    logic overrun_q, overrun_d;

    // Overrun: set when a frame lands on unread data; sticky until a host read.
    always_comb begin
        overrun_d = overrun_q;
        if (frame_done) begin
            overrun_d = overrun_q | rx_done_q;
        end else if (host_read_stt_rx_done) begin
            overrun_d = 1'b0;
        end
    end

    // Overrun flag register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) overrun_q <= 1'b0;
        else          overrun_q <= overrun_d;
    end

    assign stt_overrun = overrun_q;
`else
    assign stt_overrun = 1'b0;
`endif

    assign rx_data        = rx_data_q;
    assign stt_rx_done    = rx_done_q;
    assign stt_parity_err = parity_flag_q;
    assign stt_frame_err  = frame_flag_q;
    assign rts_n          = rx_done_q;

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Receive half of the DTI UART. Recovers serial frames on `rx` using a 16x oversampling enable, checks parity and stop bits, and presents the assembled byte plus status flags to the UART register block. Frame format (5–8 data bits, optional even/odd parity, 1 or 2 stop bits) is controlled by the same configuration fields that drive the transmitter.

## Interface
Parameters:
- `DATA_WIDTH`, default `` `CFG_DATA_WIDTH ``: width of `rx_data`. Bits [DATA_WIDTH-1:8] always read 0.

Ports:
- `clk`, input, 1: clock.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `clken`, input, 1: 16x bit-rate oversample tick, one `clk` wide.
- `rx`, input, 1: serial input, asynchronous to `clk`, idle high.
- `cfg_data_bit_num`, input, 2: data bits per frame. 00=5, 01=6, 10=7, 11=8.
- `cfg_stop_bit_num`, input, 1: stop bits per frame. 0=1, 1=2.
- `cfg_parity_en`, input, 1: parity bit present when high.
- `cfg_parity_type`, input, 1: parity sense. 0=even, 1=odd.
- `host_read_stt_rx_done`, input, 1: one-cycle pulse from the register block when the host reads the status.
- `rx_data`, output, DATA_WIDTH: last received data, LSB-aligned.
- `stt_rx_done`, output, 1: unread frame available.
- `stt_parity_err`, output, 1: parity error on the last frame.
- `stt_frame_err`, output, 1: a stop bit sampled low on the last frame.
- `stt_overrun`, output, 1: a frame completed while `stt_rx_done` was still set.
- `rts_n`, output, 1: flow control. Low means the receiver is ready to accept a frame.

## Operation
- Input synchronizer: `rx` passes through a 2-flop synchronizer (reset value 1) before use. All sampling below uses the synchronized signal `rx_s`.
- Counters:
  - `tick_cnt` (4 bits) advances only on `clken`.
  - `bit_cnt` (3 bits) counts data bits.
  - `stop_cnt` (1 bit) counts stop bits.
- State machine:
  - IDLE:
    - Clears all counters.
    - On `clken` with `rx_s`=0, go to START.
  - START:
    - On `clken` with `tick_cnt`=7 (mid-bit): if `rx_s`=0, clear `tick_cnt` and go to DATA.
    - Otherwise it was a glitch; go to IDLE with no status change.
  - DATA:
    - On `clken` with `tick_cnt`=15, shift `rx_s` into `shift[bit_cnt]` (LSB first) and increment `bit_cnt`.
    - After the bit with `bit_cnt` = N-1, where N is the number of data bits: go to PARITY if `cfg_parity_en` is set, else go to STOP.
  - PARITY:
    - On `clken` with `tick_cnt`=15, sample the parity bit.
    - Error when `rx_s` differs from the expected value: `^shift[N-1:0]` for even parity, or its inverse for odd parity.
    - Go to STOP.
  - STOP:
    - On `clken` with `tick_cnt`=15, sample the stop bit; `rx_s`=0 latches a pending frame error.
    - If `stop_cnt` equals `cfg_stop_bit_num`, the frame is complete; go to IDLE.
    - Otherwise increment `stop_cnt`.
- Frame completion (single cycle):
  - `rx_data` ← `shift` with unused upper bits set to 0.
  - `stt_parity_err` and `stt_frame_err` ← this frame's results.
  - `stt_rx_done` ← 1.
- Data is delivered even when a parity or frame error occurs.
- Configuration inputs are sampled live. Changing them mid-frame is undefined; the host changes them only while idle.
- `rts_n` = `stt_rx_done`: deasserted (high) while unread data is held.

## Timing
- Reset values:
  - `rx_data`=0, `stt_rx_done`=0, `stt_parity_err`=0, `stt_frame_err`=0, `stt_overrun`=0.
  - `rts_n`=0.
  - State=IDLE.
- Reset asserted mid-frame aborts the frame immediately with no status update.
- Status outputs are registered and update on the `clk` edge after the completing `clken`.
- Latency: the final stop sample occurs 8 ticks into the last stop bit. There is no wait for the full stop bit, so a back-to-back start bit is caught.
- `host_read_stt_rx_done` clears `stt_rx_done`, `stt_parity_err`, `stt_frame_err` and `stt_overrun` on the next edge.
- If frame completion and `host_read_stt_rx_done` occur in the same cycle, completion wins: flags reflect the new frame and `stt_rx_done` stays 1.
- `clken` low stalls every counter and the state machine.

## Configuration
- Macro: `DTI_UART_RX_OVERRUN_EN`.
- Defined:
  - `stt_overrun` is set when a frame completes while `stt_rx_done`=1.
  - `rx_data` is overwritten with the new frame.
  - `stt_overrun` is cleared by `host_read_stt_rx_done`, but a simultaneous completion takes priority.
- Undefined: `stt_overrun` is tied to 0 and its register is not instantiated. All other behaviour is unchanged.

## Test plan
- 8N1 reception: frame 0xA5 at 16 `clk` per `clken` → `rx_data`=0x0A5, `stt_rx_done`=1, both error flags 0, `rts_n`=1. Host read → `stt_rx_done`=0, `rts_n`=0.
- 5-bit odd parity, 2 stop bits: send 0x13 with parity bit 0 → `rx_data`=0x13, no error. Resend with parity bit 1 → `stt_parity_err`=1 and `rx_data` still 0x13.
- Frame error: 8N1 0x3C with the stop bit driven low → `stt_frame_err`=1 and `rx_data`=0x3C. Then a 2-stop-bit frame with only the second stop bit low → `stt_frame_err`=1.
- Start-bit glitch: drive `rx` low for 4 ticks, then high → remains in IDLE, `stt_rx_done` stays 0. A following valid 0x55 frame is received correctly.
- Overrun (macro defined): two frames 0x11 then 0x22 with no host read → `rx_data`=0x22, `stt_overrun`=1. With the macro undefined → `stt_overrun`=0.
- Corner cases: host read pulsed in the completion cycle → `stt_rx_done` stays 1. Reset asserted during the DATA state → all outputs return to reset values and the next frame is received cleanly.
